// File: rtl/ram_write_port_arbiter_pkg.sv
// ram_write_port_arbiter_pkg
//   Shared definitions for the RAM write-port arbiter: FSM state encoding and
//   writer index constants used by the top and the round-robin sub-module.
package ram_write_port_arbiter_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,  // zero-fill in progress
        ST_ARB  = 1'b1   // fill done, arbitrating writers
    } arb_state_e;

    localparam int unsigned WR0 = 0;
    localparam int unsigned WR1 = 1;

endpackage

// File: rtl/ram_write_port_arbiter_rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin arbiter with a registered priority pointer.
//   Ports:
//     Clock, Reset   clock and asynchronous active-low reset
//     enable         gates all grants (low while filling or clearing)
//     valid[1:0]     request per writer
//     grant[1:0]     one-hot grant, combinational
//     pointer        writer that wins when both request
module rr_arbiter2
    import ram_write_port_arbiter_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant,
    output logic       pointer
);

    logic pointer_d;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11) begin
                grant = pointer ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
        end
    end

    // A grant always means a transfer, so priority passes to the other writer.
    always_comb begin
        pointer_d = pointer;
        if (grant[WR0]) begin
            pointer_d = 1'b1;
        end else if (grant[WR1]) begin
            pointer_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pointer <= 1'b0;
        end else begin
            pointer <= pointer_d;
        end
    end

endmodule

// File: rtl/ram_write_port_arbiter.sv
// ram_write_port_arbiter
//   Shares the single RAM write port between two valid/ready writers with
//   round-robin arbitration. After reset or iClear every entry 0..MEM_SIZE is
//   zero-filled before any writer is accepted. Write outputs are registered.
//   Ports:
//     Clock, Reset                    clock, asynchronous active-low reset
//     iClear                          re-run the zero-fill
//     iValid0/iAddr0/iData0, oReady0  writer 0 handshake
//     iValid1/iAddr1/iData1, oReady1  writer 1 handshake
//     oWriteEnable/oWriteAddress/oWriteData  registered RAM write port
//     oInitDone                       high once the fill has completed
module ram_write_port_arbiter
    import ram_write_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MEM_SIZE   = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iClear,
    input  logic                  iValid0,
    input  logic [ADDR_WIDTH-1:0] iAddr0,
    input  logic [DATA_WIDTH-1:0] iData0,
    output logic                  oReady0,
    input  logic                  iValid1,
    input  logic [ADDR_WIDTH-1:0] iAddr1,
    input  logic [DATA_WIDTH-1:0] iData1,
    output logic                  oReady1,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [DATA_WIDTH-1:0] oWriteData,
    output logic                  oInitDone
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MEM_SIZE);

    arb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] waddr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [1:0]            grant;
    logic                  pointer;
    logic                  arb_en;

    assign arb_en = (state_q == ST_ARB) && !iClear;

    rr_arbiter2 u_rr (
        .Clock   (Clock),
        .Reset   (Reset),
        .enable  (arb_en),
        .valid   ({iValid1, iValid0}),
        .grant   (grant),
        .pointer (pointer)
    );

    // State register and registered write port
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            oWriteEnable  <= 1'b0;
            oWriteAddress <= '0;
            oWriteData    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            oWriteEnable  <= we_d;
            oWriteAddress <= waddr_d;
            oWriteData    <= wdata_d;
        end
    end

    // Next-state and next write-port values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = oWriteAddress;
        wdata_d = oWriteData;
        unique case (state_q)
            ST_INIT: begin
                if (iClear) begin
                    cnt_d = '0;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q;
                    wdata_d = '0;
                    if (cnt_q == LastAddr) begin
                        cnt_d   = '0;
                        state_d = ST_ARB;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ARB: begin
                if (iClear) begin
                    cnt_d   = '0;
                    state_d = ST_INIT;
                end else if (grant[WR0]) begin
                    we_d    = 1'b1;
                    waddr_d = iAddr0;
                    wdata_d = iData0;
                end else if (grant[WR1]) begin
                    we_d    = 1'b1;
                    waddr_d = iAddr1;
                    wdata_d = iData1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Outputs
    always_comb begin
        oReady0   = grant[WR0];
        oReady1   = grant[WR1];
        oInitDone = (state_q == ST_ARB);
    end

endmodule

// File: tb/tb_ram_write_port_arbiter.sv
module tb_ram_write_port_arbiter;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        iClear = 1'b0;
    logic        iValid0 = 1'b0, iValid1 = 1'b0;
    logic [7:0]  iAddr0 = '0, iAddr1 = '0;
    logic [15:0] iData0 = '0, iData1 = '0;
    logic        oReady0, oReady1, oWriteEnable, oInitDone;
    logic [7:0]  oWriteAddress;
    logic [15:0] oWriteData;

    int total = 0;
    int bad   = 0;

    logic [15:0] ram [0:255];

    ram_write_port_arbiter #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (8),
        .MEM_SIZE   (8)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iClear        (iClear),
        .iValid0       (iValid0),
        .iAddr0        (iAddr0),
        .iData0        (iData0),
        .oReady0       (oReady0),
        .iValid1       (iValid1),
        .iAddr1        (iAddr1),
        .iData1        (iData1),
        .oReady1       (oReady1),
        .oWriteEnable  (oWriteEnable),
        .oWriteAddress (oWriteAddress),
        .oWriteData    (oWriteData),
        .oInitDone     (oInitDone)
    );

    always #5 Clock = ~Clock;

    // Reference RAM: captures what the real RAM would write at each edge.
    always @(posedge Clock) begin
        if (oWriteEnable) ram[oWriteAddress] <= oWriteData;
    end

    typedef struct {
        logic        clr;
        logic        v0;
        logic [7:0]  a0;
        logic [15:0] d0;
        logic        v1;
        logic [7:0]  a1;
        logic [15:0] d1;
        logic        r0;
        logic        r1;
        logic        we;
        logic [7:0]  wa;
        logic [15:0] wd;
    } vec_t;

    vec_t vecs [0:10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with state INIT and counter 0; leaves at a negedge in ARB.
    task automatic check_fill(input string tag);
        for (int i = 0; i <= 8; i++) begin
            #1;
            check({tag, " fill ready0"}, {31'b0, oReady0}, 0);
            check({tag, " fill ready1"}, {31'b0, oReady1}, 0);
            @(posedge Clock); #1;
            check({tag, " fill we"}, {31'b0, oWriteEnable}, 1);
            check({tag, " fill addr"}, {24'b0, oWriteAddress}, i);
            check({tag, " fill data"}, {16'b0, oWriteData}, 0);
            check({tag, " fill initdone"}, {31'b0, oInitDone}, (i == 8) ? 1 : 0);
            @(negedge Clock);
        end
    endtask

    initial begin
        vecs[0]  = '{0, 1, 1, 16'h0011, 1, 2, 16'h0022, 1, 0, 1, 1, 16'h0011};
        vecs[1]  = '{0, 1, 1, 16'h0011, 1, 2, 16'h0022, 0, 1, 1, 2, 16'h0022};
        vecs[2]  = '{0, 1, 1, 16'h0011, 1, 2, 16'h0022, 1, 0, 1, 1, 16'h0011};
        vecs[3]  = '{0, 1, 1, 16'h0011, 1, 2, 16'h0022, 0, 1, 1, 2, 16'h0022};
        vecs[4]  = '{0, 1, 3, 16'hA5A5, 0, 0, 16'h0000, 1, 0, 1, 3, 16'hA5A5};
        vecs[5]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 3, 16'hA5A5};
        vecs[6]  = '{0, 0, 0, 16'h0000, 1, 7, 16'h7777, 0, 1, 1, 7, 16'h7777};
        vecs[7]  = '{0, 1, 4, 16'h4444, 0, 0, 16'h0000, 1, 0, 1, 4, 16'h4444};
        // pointer now 1: writer 1 wins first, then writer 0 lands last on addr 5
        vecs[8]  = '{0, 1, 5, 16'h1111, 1, 5, 16'h2222, 0, 1, 1, 5, 16'h2222};
        vecs[9]  = '{0, 1, 5, 16'h1111, 0, 5, 16'h2222, 1, 0, 1, 5, 16'h1111};
        // clear wins over a pending writer 1 request
        vecs[10] = '{1, 0, 0, 16'h0000, 1, 6, 16'h6666, 0, 0, 0, 5, 16'h1111};

        // Reset state
        #3;
        check("rst we", {31'b0, oWriteEnable}, 0);
        check("rst addr", {24'b0, oWriteAddress}, 0);
        check("rst data", {16'b0, oWriteData}, 0);
        check("rst initdone", {31'b0, oInitDone}, 0);
        check("rst ready0", {31'b0, oReady0}, 0);
        @(negedge Clock);
        Reset   = 1'b1;
        iValid0 = 1'b1;  // must be ignored during fill
        iValid1 = 1'b1;
        check_fill("boot");

        // Table-driven arbitration vectors
        for (int i = 0; i <= 10; i++) begin
            iClear  = vecs[i].clr;
            iValid0 = vecs[i].v0;
            iAddr0  = vecs[i].a0;
            iData0  = vecs[i].d0;
            iValid1 = vecs[i].v1;
            iAddr1  = vecs[i].a1;
            iData1  = vecs[i].d1;
            #1;
            check($sformatf("vec%0d ready0", i), {31'b0, oReady0}, {31'b0, vecs[i].r0});
            check($sformatf("vec%0d ready1", i), {31'b0, oReady1}, {31'b0, vecs[i].r1});
            @(posedge Clock); #1;
            check($sformatf("vec%0d we", i), {31'b0, oWriteEnable}, {31'b0, vecs[i].we});
            check($sformatf("vec%0d addr", i), {24'b0, oWriteAddress}, {24'b0, vecs[i].wa});
            check($sformatf("vec%0d data", i), {16'b0, oWriteData}, {16'b0, vecs[i].wd});
            @(negedge Clock);
        end
        check("ram5 later grant wins", {16'b0, ram[5]}, 32'h1111);

        // Clear in ARB: full refill, writer 1 still waiting, then accepted
        iClear = 1'b0;
        check("clear initdone low", {31'b0, oInitDone}, 0);
        check_fill("clear");
        #1;
        check("post-clear ready1", {31'b0, oReady1}, 1);
        check("post-clear ready0", {31'b0, oReady0}, 0);
        @(posedge Clock); #1;
        check("post-clear we", {31'b0, oWriteEnable}, 1);
        check("post-clear addr", {24'b0, oWriteAddress}, 32'h6);
        check("post-clear data", {16'b0, oWriteData}, 32'h6666);
        @(negedge Clock);
        iValid1 = 1'b0;

        // Reset mid-fill at counter 4
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        repeat (4) @(negedge Clock);
        check("pre-reset we", {31'b0, oWriteEnable}, 1);
        check("pre-reset addr", {24'b0, oWriteAddress}, 3);
        Reset = 1'b0;
        #1;
        check("midfill rst we", {31'b0, oWriteEnable}, 0);
        check("midfill rst addr", {24'b0, oWriteAddress}, 0);
        check("midfill rst data", {16'b0, oWriteData}, 0);
        @(negedge Clock);
        Reset = 1'b1;
        check_fill("refill");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
